// File: rtl/mem_ctrl_pkg.sv
// Shared types and lane-strobe constants for the MEM-stage data memory controller.
// Lane numbering is big-endian: strobe bit [3] is the most significant byte lane.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    localparam logic [3:0] STRB_NONE     = 4'b0000;
    localparam logic [3:0] STRB_WORD     = 4'b1111;
    localparam logic [3:0] STRB_HI_HALF  = 4'b1100;
    localparam logic [3:0] STRB_LO_HALF  = 4'b0011;
    localparam logic [3:0] STRB_MSB_BYTE = 4'b1000;

    // Byte takes priority over half; neither set means a full word access.
    function automatic mem_size_t decode_size(input logic isByte, input logic isHalf);
        if (isByte) begin
            return SZ_BYTE;
        end
        if (isHalf) begin
            return SZ_HALF;
        end
        return SZ_WORD;
    endfunction

endpackage

// File: rtl/data_align.sv
// Combinational big-endian alignment: store lane strobes/replication, load
// extraction with zero/sign extension, and unaligned-address detection.
module data_align
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        size_i,
    input  logic [1:0]        offset_i,
    input  logic [DATA_W-1:0] writeData_i,
    input  logic [1:0]        loadSize_i,
    input  logic [1:0]        loadOffset_i,
    input  logic              loadSign_i,
    input  logic [DATA_W-1:0] memData_i,
    output logic [3:0]        strobe_o,
    output logic [DATA_W-1:0] laneData_o,
    output logic [DATA_W-1:0] loadData_o,
    output logic              addrError_o
);

    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    always_comb begin
        strobe_o    = STRB_WORD;
        laneData_o  = writeData_i;
        addrError_o = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                strobe_o   = STRB_MSB_BYTE >> offset_i;
                laneData_o = {4{writeData_i[7:0]}};
            end
            SZ_HALF: begin
                strobe_o    = offset_i[1] ? STRB_LO_HALF : STRB_HI_HALF;
                laneData_o  = {2{writeData_i[15:0]}};
                addrError_o = offset_i[0];
            end
            default: begin
                addrError_o = |offset_i;
            end
        endcase
    end

    // Offset 0 is the most significant byte/halfword of the memory word.
    always_comb begin
        loadByte = memData_i[31:24];
        case (loadOffset_i)
            2'd0: loadByte = memData_i[31:24];
            2'd1: loadByte = memData_i[23:16];
            2'd2: loadByte = memData_i[15:8];
            default: loadByte = memData_i[7:0];
        endcase
        loadHalf = loadOffset_i[1] ? memData_i[15:0] : memData_i[31:16];
        case (loadSize_i)
            SZ_BYTE: loadData_o = {{24{loadSign_i & loadByte[7]}}, loadByte};
            SZ_HALF: loadData_o = {{16{loadSign_i & loadHalf[15]}}, loadHalf};
            default: loadData_o = memData_i;
        endcase
    end

endmodule

// File: rtl/data_mem_controller.sv
// MEM-stage data memory controller: registered, Ack-based memory transactions
// with stall generation. Define LLSC_EN to build LL/SC link tracking.
module data_mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemByte,
    input  logic              MemHalf,
    input  logic              MemSignExtend,
    input  logic              LLSC,
    input  logic              ERET,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              Stall,
    output logic [DATA_W-1:0] ReadData,
    output logic              M_Stall_Controller,
    output logic              AddrError,
    output logic [29:0]       DataMem_Address,
    output logic              DataMem_ReadEnable,
    output logic [3:0]        DataMem_WriteEnable,
    output logic [DATA_W-1:0] DataMem_WriteData,
    input  logic [DATA_W-1:0] DataMem_ReadData,
    input  logic              DataMem_Ack
);

    mem_state_t        state_q, state_d;
    mem_size_t         accessSize;
    logic [ADDR_W-3:0] addr_q, addr_d;
    logic              readEn_q, readEn_d;
    logic [3:0]        writeEn_q, writeEn_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] readData_q, readData_d;
    logic [1:0]        loadSize_q, loadSize_d;
    logic [1:0]        loadOffset_q, loadOffset_d;
    logic              loadSign_q, loadSign_d;
    logic              isStore_q, isStore_d;
    logic              isSc_q, isSc_d;

    logic [3:0]        strobe;
    logic [DATA_W-1:0] laneData;
    logic [DATA_W-1:0] loadData;
    logic              req;
    logic              scFail;

    assign accessSize = decode_size(MemByte, MemHalf);

    data_align #(.DATA_W(DATA_W)) u_align (
        .size_i       (accessSize),
        .offset_i     (Address[1:0]),
        .writeData_i  (WriteData),
        .loadSize_i   (loadSize_q),
        .loadOffset_i (loadOffset_q),
        .loadSign_i   (loadSign_q),
        .memData_i    (DataMem_ReadData),
        .strobe_o     (strobe),
        .laneData_o   (laneData),
        .loadData_o   (loadData),
        .addrError_o  (AddrError)
    );

    assign req = (MemRead | MemWrite) & ~AddrError;

`ifdef LLSC_EN
    logic              isLl_q, isLl_d;
    logic              linkValid_q, linkValid_d;
    logic [ADDR_W-3:0] linkAddr_q, linkAddr_d;

    // A failing SC never touches memory; it completes straight from IDLE.
    assign scFail = MemWrite & LLSC
                  & ~(linkValid_q & (linkAddr_q == Address[ADDR_W-1:2]));
`else
    logic unusedEret;
    assign unusedEret = ERET;
    assign scFail     = 1'b0;
`endif

    assign M_Stall_Controller = req & ~scFail & (state_q != DONE);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        readEn_d     = readEn_q;
        writeEn_d    = writeEn_q;
        wdata_d      = wdata_q;
        readData_d   = readData_q;
        loadSize_d   = loadSize_q;
        loadOffset_d = loadOffset_q;
        loadSign_d   = loadSign_q;
        isStore_d    = isStore_q;
        isSc_d       = isSc_q;
`ifdef LLSC_EN
        isLl_d       = isLl_q;
        linkValid_d  = linkValid_q;
        linkAddr_d   = linkAddr_q;
`endif
        case (state_q)
            IDLE: begin
                if (req && scFail) begin
                    state_d    = DONE;
                    readData_d = '0;
                end else if (req) begin
                    state_d      = ACCESS;
                    addr_d       = Address[ADDR_W-1:2];
                    wdata_d      = laneData;
                    writeEn_d    = MemWrite ? strobe : STRB_NONE;
                    readEn_d     = ~MemWrite;
                    loadSize_d   = accessSize;
                    loadOffset_d = Address[1:0];
                    loadSign_d   = MemSignExtend;
                    isStore_d    = MemWrite;
                    isSc_d       = MemWrite & LLSC;
`ifdef LLSC_EN
                    isLl_d       = ~MemWrite & LLSC;
`endif
                end
            end
            ACCESS: begin
                if (DataMem_Ack) begin
                    state_d    = DONE;
                    readEn_d   = 1'b0;
                    writeEn_d  = STRB_NONE;
                    readData_d = isSc_q ? {{(DATA_W-1){1'b0}}, 1'b1} : loadData;
`ifdef LLSC_EN
                    if (isStore_q && (addr_q == linkAddr_q)) begin
                        linkValid_d = 1'b0;
                    end else if (isLl_q) begin
                        linkValid_d = 1'b1;
                        linkAddr_d  = addr_q;
                    end
`endif
                end
            end
            DONE: begin
                if (!Stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef LLSC_EN
        if (ERET) begin
            linkValid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            readEn_q     <= 1'b0;
            writeEn_q    <= STRB_NONE;
            wdata_q      <= '0;
            readData_q   <= '0;
            loadSize_q   <= SZ_WORD;
            loadOffset_q <= 2'd0;
            loadSign_q   <= 1'b0;
            isStore_q    <= 1'b0;
            isSc_q       <= 1'b0;
`ifdef LLSC_EN
            isLl_q       <= 1'b0;
            linkValid_q  <= 1'b0;
            linkAddr_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            readEn_q     <= readEn_d;
            writeEn_q    <= writeEn_d;
            wdata_q      <= wdata_d;
            readData_q   <= readData_d;
            loadSize_q   <= loadSize_d;
            loadOffset_q <= loadOffset_d;
            loadSign_q   <= loadSign_d;
            isStore_q    <= isStore_d;
            isSc_q       <= isSc_d;
`ifdef LLSC_EN
            isLl_q       <= isLl_d;
            linkValid_q  <= linkValid_d;
            linkAddr_q   <= linkAddr_d;
`endif
        end
    end

    assign DataMem_Address     = addr_q;
    assign DataMem_ReadEnable  = readEn_q;
    assign DataMem_WriteEnable = writeEn_q;
    assign DataMem_WriteData   = wdata_q;
    assign ReadData            = readData_q;

endmodule

// File: doc/data_mem_controller.md
Name: data_mem_controller

Overview:
- MEM-stage data memory controller for the MIPS-III pipeline.
- Sits between the MEM pipeline register and the external data memory port.
- Converts load/store requests into a registered, acknowledge-based memory transaction and drives M_Stall_Controller into the hazard controller.
- Performs big-endian sub-word alignment and extension, and optional LL/SC tracking.

Parameters:
ADDR_W, 32, byte address width of MEM-stage address
DATA_W, 32, data bus width (fixed 32; parameterised for lint only)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
MemRead  in  1  MEM-stage load request
MemWrite  in  1  MEM-stage store request
MemByte  in  1  byte-sized access
MemHalf  in  1  halfword-sized access (MemByte=MemHalf=0 means word)
MemSignExtend  in  1  sign-extend sub-word loads
LLSC  in  1  instruction is LL (with MemRead) or SC (with MemWrite)
ERET  in  1  clears LL link bit
Address  in  ADDR_W  byte address
WriteData  in  DATA_W  store data, right-justified
Stall  in  1  global M_Stall from hazard controller
ReadData  out  DATA_W  load result, or SC success flag
M_Stall_Controller  out  1  MEM stall request to hazard controller
AddrError  out  1  unaligned access flag, combinational
DataMem_Address  out  30  word address
DataMem_ReadEnable  out  1  read strobe, registered
DataMem_WriteEnable  out  4  byte-lane strobes, [3] = MSB lane, registered
DataMem_WriteData  out  DATA_W  lane-replicated store data
DataMem_ReadData  in  DATA_W  memory read data
DataMem_Ack  in  1  memory completion, one cycle

Behaviour:
Clocking and reset:
- One clock `clock`; reset `reset` is synchronous and active-high.
- On reset: state=IDLE; all DataMem_* outputs=0; ReadData=0; link bit=0.
- Reset mid-transaction abandons the access; the memory must tolerate a dropped request.

Request qualification:
- req = (MemRead|MemWrite) & ~AddrError.
- MemRead and MemWrite both high: treated as a store.

AddrError:
- Set when MemHalf & Address[0], or word & Address[1:0]!=0.
- When set: no access, no stall.

State machine (IDLE, ACCESS, DONE):
- IDLE: on req, register the address, byte strobes and aligned data, assert ReadEnable or WriteEnable, go to ACCESS. DataMem_Ack is ignored in IDLE.
- ACCESS: strobes held stable until Ack. On Ack, capture the extracted load data into ReadData, drop the strobes, go to DONE.
- DONE: no strobes.
  - Stall=0: return to IDLE (the instruction leaves MEM at this edge).
  - Stall=1: hold DONE; do not reissue the access; ReadData stable. Ack is ignored.

M_Stall_Controller:
- Defined as req & (state!=DONE); combinational.
- Minimum 2 stall cycles with a zero-wait memory: IDLE, then ACCESS+Ack, then DONE unstalled.

Store alignment (big-endian):
- Byte: strobe = 4'b1000 >> Address[1:0]; data = {4{WriteData[7:0]}}.
- Half: strobe = Address[1] ? 4'b0011 : 4'b1100; data = {2{WriteData[15:0]}}.
- Word: strobe = 4'b1111.

Load extraction:
- Byte offset 0 selects bits [31:24]; halfword offset 0 selects [31:16].
- Zero- or sign-extend per MemSignExtend.

Optional Feature:
LLSC_EN defined:
- LL sets the link bit and link word address on completion.
- SC with link valid and matching word address: performs a word store; ReadData=1.
- SC otherwise: no memory access, no stall; ReadData=0 from the next cycle; state goes IDLE->DONE directly.
- Any completed store to the link address, or ERET, clears the link bit.

LLSC_EN undefined:
- LLSC input ignored; LL behaves as LW.
- SC behaves as SW and returns ReadData=1.
- No link storage synthesised.

Decomposition:
Package mem_ctrl_pkg:
- mem_state_t enum {IDLE, ACCESS, DONE}.
- mem_size_t {SZ_BYTE, SZ_HALF, SZ_WORD}.
- Lane-strobe constants.

Sub-module data_align (combinational):
- Store lane strobes and replication.
- Load extraction and extension.
- AddrError generation.

Test Plan:
- LW 0x100, Ack on 1st ACCESS cycle, DataMem_ReadData=0xDEADBEEF -> Stall high 2 cycles, ReadData=0xDEADBEEF in DONE, ReadEnable high exactly 1 cycle.
- LB signed at 0x103 with memory 0x112233F0 -> ReadData=0xFFFFFFF0. LBU same -> 0x000000F0.
- SH 0x202, WriteData=0xABCD1234 -> WriteEnable=4'b0011, WriteData bus=0x12341234, Address=0x80.
- LW 0x102 -> AddrError=1, M_Stall_Controller=0, no strobes.
- Ack delayed 5 cycles, then Stall held high 3 more cycles in DONE -> single access only; ReadData stable; back to IDLE when Stall=0.
- LLSC_EN: LL 0x40, SC 0x40 -> store issued, ReadData=1. LL 0x40, ERET, SC 0x40 -> no store, ReadData=0. Reset asserted during ACCESS -> strobes 0 next cycle, state IDLE.
